// File: rtl/adder_pkg.sv
// Shared constants for the pipelined carry-lookahead adder.
package adder_pkg;

    localparam int WIDTH       = 16;
    localparam int SLICE_W     = 4;
    localparam int N_SLICES    = WIDTH / SLICE_W;
    localparam int ADD_LATENCY = 4;

endpackage

// File: rtl/cla_4bit.sv
// 4-bit carry-lookahead slice; all carries flattened to two logic levels.
module cla_4bit
    import adder_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] pr;
    logic [SLICE_W:0]   c;

    assign g  = x & y;
    assign pr = x ^ y;

    assign c[0] = cin;
    assign c[1] = g[0] | (pr[0] & cin);
    assign c[2] = g[1] | (pr[1] & g[0]) | (pr[1] & pr[0] & cin);
    assign c[3] = g[2] | (pr[2] & g[1]) | (pr[2] & pr[1] & g[0])
                | (pr[2] & pr[1] & pr[0] & cin);
    assign c[4] = g[3] | (pr[3] & g[2]) | (pr[3] & pr[2] & g[1])
                | (pr[3] & pr[2] & pr[1] & g[0])
                | (pr[3] & pr[2] & pr[1] & pr[0] & cin);

    assign s    = pr ^ c[SLICE_W-1:0];
    assign cout = c[SLICE_W];

endmodule

// File: rtl/adder_32bit.sv
// 16-bit adder, one 4-bit lookahead slice per stage; operands are skewed
// in and finished sum nibbles deskewed so each result leaves with its carry.
module adder_32bit
    import adder_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             carryin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p,
    output logic             carryout
);

    logic [SLICE_W-1:0] n0_s, n1_s, n2_s, n3_s;
    logic               n0_c, n1_c, n2_c, n3_c;

    logic [SLICE_W-1:0]         s1_sum;
    logic                       s1_c;
    logic [WIDTH-SLICE_W-1:0]   s1_a, s1_d;

    logic [2*SLICE_W-1:0]       s2_sum;
    logic                       s2_c;
    logic [WIDTH-2*SLICE_W-1:0] s2_a, s2_d;

    logic [3*SLICE_W-1:0]       s3_sum;
    logic                       s3_c;
    logic [SLICE_W-1:0]         s3_a, s3_d;

    cla_4bit u_cla0 (
        .x    (a[SLICE_W-1:0]),
        .y    (d[SLICE_W-1:0]),
        .cin  (carryin),
        .s    (n0_s),
        .cout (n0_c)
    );

    cla_4bit u_cla1 (
        .x    (s1_a[SLICE_W-1:0]),
        .y    (s1_d[SLICE_W-1:0]),
        .cin  (s1_c),
        .s    (n1_s),
        .cout (n1_c)
    );

    cla_4bit u_cla2 (
        .x    (s2_a[SLICE_W-1:0]),
        .y    (s2_d[SLICE_W-1:0]),
        .cin  (s2_c),
        .s    (n2_s),
        .cout (n2_c)
    );

    cla_4bit u_cla3 (
        .x    (s3_a),
        .y    (s3_d),
        .cin  (s3_c),
        .s    (n3_s),
        .cout (n3_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_sum   <= '0;
            s1_c     <= 1'b0;
            s1_a     <= '0;
            s1_d     <= '0;
            s2_sum   <= '0;
            s2_c     <= 1'b0;
            s2_a     <= '0;
            s2_d     <= '0;
            s3_sum   <= '0;
            s3_c     <= 1'b0;
            s3_a     <= '0;
            s3_d     <= '0;
            p        <= '0;
            carryout <= 1'b0;
        end else begin
            s1_sum   <= n0_s;
            s1_c     <= n0_c;
            s1_a     <= a[WIDTH-1:SLICE_W];
            s1_d     <= d[WIDTH-1:SLICE_W];
            s2_sum   <= {n1_s, s1_sum};
            s2_c     <= n1_c;
            s2_a     <= s1_a[WIDTH-SLICE_W-1:SLICE_W];
            s2_d     <= s1_d[WIDTH-SLICE_W-1:SLICE_W];
            s3_sum   <= {n2_s, s2_sum};
            s3_c     <= n2_c;
            s3_a     <= s2_a[WIDTH-2*SLICE_W-1:SLICE_W];
            s3_d     <= s2_d[WIDTH-2*SLICE_W-1:SLICE_W];
            p        <= {n3_s, s3_sum};
            carryout <= n3_c;
        end
    end

endmodule

// File: tb/tb_adder_32bit.sv
// Bench for adder_32bit: directed cases plus random traffic against a
// delay-line model of a + d + carryin.
module tb_adder_32bit;
    import adder_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             carryin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] p;
    logic             carryout;

    int checks = 0;
    int errors = 0;

    logic [WIDTH:0] mq[$];
    logic [WIDTH:0] obs;

    adder_32bit dut (
        .clk      (clk),
        .rst      (rst),
        .carryin  (carryin),
        .a        (a),
        .d        (d),
        .p        (p),
        .carryout (carryout)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH:0] got,
                         input logic [WIDTH:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // One clock: drive, clock, advance model, sample and compare.
    task automatic step(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] td,
                        input logic tc, input logic tr,
                        output logic [WIDTH:0] o);
        a       = ta;
        d       = td;
        carryin = tc;
        rst     = tr;
        @(posedge clk);
        if (tr) begin
            mq.delete();
            repeat (ADD_LATENCY) mq.push_back('0);
        end else begin
            mq.push_back({1'b0, ta} + {1'b0, td} + {{WIDTH{1'b0}}, tc});
            void'(mq.pop_front());
        end
        #1;
        o = {carryout, p};
        check("model", o, mq[0]);
    endtask

    initial begin
        a = '0;
        d = '0;
        carryin = 1'b0;
        rst = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step(16'h1234, 16'h1111, 1'b0, 1'b1, obs);
            check("rst_hold", obs, 17'h0);
        end
        for (int i = 0; i < ADD_LATENCY; i++) begin
            step(16'h1234, 16'h1111, 1'b0, 1'b0, obs);
            if (i < ADD_LATENCY - 1)
                check("rst_flush", obs, 17'h0);
        end
        check("rst_first", obs, 17'h02345);

        repeat (30) step(16'd510, 16'd60, 1'b0, 1'b0, obs);
        check("sum570", obs, 17'd570);
        repeat (30) step(16'd30, 16'd600, 1'b0, 1'b0, obs);
        check("sum630", obs, 17'd630);
        repeat (30) step(16'd1500, 16'd1160, 1'b0, 1'b0, obs);
        check("sum2660", obs, 17'd2660);
        repeat (30) step(16'd520, 16'd602, 1'b0, 1'b0, obs);
        check("sum1122", obs, 17'd1122);

        repeat (8) step(16'hFFFF, 16'h0000, 1'b1, 1'b0, obs);
        check("wrap", obs, 17'h10000);
        repeat (8) step(16'h0FFF, 16'h0001, 1'b0, 1'b0, obs);
        check("chain", obs, 17'h01000);
        repeat (8) step(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, obs);
        check("max_c1", obs, 17'h1FFFF);
        repeat (8) step(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, obs);
        check("max_c0", obs, 17'h1FFFE);

        for (int i = 0; i < 11; i++) begin
            if (i < 8)
                step(16'(i + 1), 16'(i + 1), 1'b0, 1'b0, obs);
            else
                step(16'h0, 16'h0, 1'b0, 1'b0, obs);
            if (i >= ADD_LATENCY - 1)
                check("b2b", obs, 17'(2 * (i - 2)));
        end

        step(16'd100, 16'd1, 1'b0, 1'b0, obs);
        step(16'd200, 16'd2, 1'b0, 1'b0, obs);
        step(16'd300, 16'd3, 1'b1, 1'b0, obs);
        step(16'd400, 16'd4, 1'b0, 1'b1, obs);
        check("mid_rst", obs, 17'h0);
        step(16'd7, 16'd7, 1'b0, 1'b0, obs);
        check("mid_z0", obs, 17'h0);
        step(16'd9, 16'd9, 1'b0, 1'b0, obs);
        check("mid_z1", obs, 17'h0);
        step(16'd9, 16'd9, 1'b0, 1'b0, obs);
        check("mid_z2", obs, 17'h0);
        step(16'd9, 16'd9, 1'b0, 1'b0, obs);
        check("mid_first", obs, 17'd14);

        for (int i = 0; i < 400; i++) begin
            step(16'($urandom), 16'($urandom), 1'($urandom),
                 ($urandom_range(0, 39) == 0), obs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_32bit.md
# adder_32bit

Pipelined 16-bit binary adder with carry-in and carry-out, despite its legacy name. It is built from four 4-bit carry-lookahead slices, one slice per pipeline stage, so that it sustains one addition per clock. It is a datapath arithmetic leaf used by the project's wider arithmetic blocks and is exercised standalone by the adder bench.

## Interface
- Parameters: none. Width is fixed at 16 bits and the slice width at 4 bits; both come from the shared package.
- clk  input  1  rising-edge clock; every register in the block uses it.
- rst  input  1  synchronous, active-high reset.
- carryin  input  1  carry into bit 0.
- a  input  16  unsigned operand A.
- d  input  16  unsigned operand B.
- p  output  16  registered sum, a + d + carryin, modulo 2^16.
- carryout  output  1  registered carry out of bit 15.

## Operation
- Result: {carryout, p} = a + d + carryin, computed as a 17-bit unsigned sum. There is no signed interpretation and no overflow flag.
- Stage 1 (first edge):
  - Slice 0 adds a[3:0] + d[3:0] + carryin.
  - Registered: sum nibble 0, carry c4, a[15:4], d[15:4].
- Stage 2: slice 1 adds the registered a[7:4] + d[7:4] + c4. Registered: sum nibbles 1..0, c8, the remaining operand bits.
- Stage 3: slice 2 adds bits [11:8] with c8. Registered: sum nibbles 2..0, c12, a[15:12], d[15:12].
- Stage 4: slice 3 adds bits [15:12] with c12. Registered: p[15:0] and carryout.
- Each slice:
  - Computes generate g = a & d and propagate pr = a ^ d per bit.
  - Uses lookahead carries c(i+1) = g(i) | pr(i) & c(i), expanded two-level within the slice, with no ripple.
  - Sum bit = pr ^ carry.
- Operands already-summed bits travel alongside each operation, so each result emerges aligned in the same cycle as its own carryout.
- There are no handshake or valid signals. Inputs are sampled on every edge and a new result emerges every edge.

## Timing
- Latency: inputs present before rising edge k appear on p/carryout immediately after edge k+3, i.e. 4 edges inclusive. Throughput is 1 result per cycle.
- Reset (rst=1 at an edge): every pipeline register, including p and carryout, clears to 0 on that edge.
  - p=0 and carryout=0 are held while rst stays high.
- Reset mid-operation: results in flight are discarded, not completed.
  - After rst deasserts, outputs stay 0 for 3 further edges; this is the flushed-zero pipeline, 0+0+0.
  - The first post-reset operand set then appears under the normal latency rule.
- Before the first reset, register contents are undefined. The bench must assert rst for at least 1 edge.
- Wrap-around:
  - 0xFFFF + 0x0000 + 1 gives p=0x0000, carryout=1.
  - 0xFFFF + 0xFFFF + 1 gives p=0xFFFF, carryout=1.
- Operand changes on consecutive cycles yield independent, correctly ordered results. There is no interaction between operations in flight.
- Inputs may be held constant for many cycles. The outputs then stay constant at that sum.

## Structure
- Shared package adder_pkg holds:
  - WIDTH = 16
  - SLICE_W = 4
  - N_SLICES = WIDTH / SLICE_W = 4
  - the latency constant ADD_LATENCY = 4, which the bench also uses
- Sub-module cla_4bit:
  - Purely combinational.
  - Ports: x[3:0], y[3:0], cin, s[3:0], cout.
  - Instantiated 4 times, one per stage.
- The top level contains only the skew/deskew pipeline registers and the slice instances. It contains no other arithmetic.

## Test plan
- Reset: hold rst=1 for 3 edges with a=0x1234, d=0x1111 -> p=0, carryout=0 throughout; after release, p=0x2345 appears exactly 4 edges later.
- Basic sums, carryin=0, each held 30 cycles (clock period 20 ns):
  - 510+60 -> p=570, carryout=0
  - 30+600 -> p=630, carryout=0
  - 1500+1160 -> p=2660, carryout=0
  - 520+602 -> p=1122, carryout=0
- Carry chain: a=0xFFFF, d=0x0000, carryin=1 -> p=0x0000, carryout=1. Separately, a=0x0FFF, d=0x0001, carryin=0 -> p=0x1000, carryout=0; this checks the carry crossing all slice boundaries.
- Maximum: a=0xFFFF, d=0xFFFF, carryin=1 -> p=0xFFFF, carryout=1. With carryin=0 -> p=0xFFFE, carryout=1.
- Back-to-back throughput: change operands every cycle over 8 cycles (1+1, 2+2, ..., 8+8) -> p reads 2, 4, ..., 16 on 8 consecutive cycles, the first one 4 edges after the first input.
- Reset mid-stream: assert rst for 1 edge while 3 operations are in flight -> none of them appear, and outputs are 0 until the first post-reset result arrives.
